// File: rtl/tone_synth_pkg.sv
// ============================================================================
// Module  : tone_synth_pkg
// Brief   : Shared widths, reset defaults and scale clamping for the tone path
// Revision: 1.0
// ============================================================================
`default_nettype none

package tone_synth_pkg;

   localparam int unsigned SCALE_W = 6;
   localparam int unsigned VOL_W   = 3;

   typedef logic [SCALE_W-1:0] scale_t;
   typedef logic [VOL_W-1:0]   vol_t;

   localparam scale_t SCALE_DEFAULT = 6'd41;
   localparam scale_t SCALE_FLOOR   = 6'd2;
   localparam scale_t SCALE_ONE     = 6'd1;
   localparam vol_t   VOL_ONE       = 3'd1;

   // A period needs at least one high and one low sample.
   function automatic scale_t clamp_scale(input scale_t s);
      return (s < SCALE_FLOOR) ? SCALE_FLOOR : s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tone_synth_sample_prescaler.sv
// ============================================================================
// Module  : sample_prescaler
// Brief   : Divides sysclk down to a one-cycle sample strobe every SAMPLE_DIV
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_prescaler #(
   parameter int unsigned SAMPLE_DIV = 8192
) (
   input  logic sysclk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned             c_cnt_w    = $clog2(SAMPLE_DIV);
   localparam logic [c_cnt_w-1:0]      c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);
   localparam logic [c_cnt_w-1:0]      c_cnt_one  = c_cnt_w'(1);

   logic [c_cnt_w-1:0] pre_cnt_q, pre_cnt_d;
   logic               tick_q, tick_d;

   always_comb begin
      pre_cnt_d = '0;
      tick_d    = 1'b0;
      if (enable) begin
         tick_d    = (pre_cnt_q == c_cnt_last);
         pre_cnt_d = tick_d ? '0 : (pre_cnt_q + c_cnt_one);
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         pre_cnt_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         tick_q    <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/tone_synth.sv
// ============================================================================
// Module  : tone_synth
// Brief   : Scale-driven square-wave tone with glitch-free period changes and
//           PWM volume gating for the audio pin
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_synth
   import tone_synth_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 8192
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic               enable,
   input  logic [SCALE_W-1:0] Scale,
   input  logic [VOL_W-1:0]   Volume,
   output logic               sample_tick,
   output logic               period_start,
   output logic               tone,
   output logic               audio,
   output logic [SCALE_W-1:0] active_scale
);

   logic   w_tick;
   scale_t w_clamped;

   scale_t phase_q, phase_d;
   scale_t active_scale_q, active_scale_d;
   logic   period_start_q, period_start_d;
   logic   tone_q, tone_d;
   logic   audio_q, audio_d;
   vol_t   pwm_cnt_q, pwm_cnt_d;

   sample_prescaler #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_prescaler (
      .sysclk (sysclk),
      .reset  (reset),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_clamped = clamp_scale(Scale);

   // Disable outranks a coincident wrapping tick, so no period_start escapes.
   always_comb begin
      phase_d        = phase_q;
      active_scale_d = active_scale_q;
      period_start_d = 1'b0;
      if (!enable) begin
         phase_d        = '0;
         active_scale_d = w_clamped;
      end else if (w_tick) begin
         if (phase_q == (active_scale_q - SCALE_ONE)) begin
            phase_d        = '0;
            active_scale_d = w_clamped;
            period_start_d = 1'b1;
         end else begin
            phase_d = phase_q + SCALE_ONE;
         end
      end
   end

   always_comb begin
      tone_d    = enable & (phase_q < (active_scale_q >> 1));
      audio_d   = tone_q & (pwm_cnt_q < Volume);
      pwm_cnt_d = pwm_cnt_q + VOL_ONE;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         phase_q        <= '0;
         active_scale_q <= SCALE_DEFAULT;
         period_start_q <= 1'b0;
         tone_q         <= 1'b0;
         audio_q        <= 1'b0;
         pwm_cnt_q      <= '0;
      end else begin
         phase_q        <= phase_d;
         active_scale_q <= active_scale_d;
         period_start_q <= period_start_d;
         tone_q         <= tone_d;
         audio_q        <= audio_d;
         pwm_cnt_q      <= pwm_cnt_d;
      end
   end

   assign sample_tick  = w_tick;
   assign period_start = period_start_q;
   assign tone         = tone_q;
   assign audio        = audio_q;
   assign active_scale = active_scale_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_synth.sv
// ============================================================================
// Module  : tb_tone_synth
// Brief   : Randomised bench for tone_synth against an integer reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tone_synth;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [5:0] scale = 6'd0;
   logic [2:0] vol = 3'd0;

   logic       sample_tick, period_start, tone, audio;
   logic [5:0] active_scale;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state, plain integers
   int m_pre, m_phase, m_scale, m_pwm;
   bit m_tick, m_ps, m_tone, m_audio;

   int last_ps = -1;
   int exp_len = 0;

   tone_synth #(.SAMPLE_DIV(DIV)) dut (
      .sysclk       (clk),
      .reset        (rst),
      .enable       (en),
      .Scale        (scale),
      .Volume       (vol),
      .sample_tick  (sample_tick),
      .period_start (period_start),
      .tone         (tone),
      .audio        (audio),
      .active_scale (active_scale)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int clampi(input int s);
      return (s < 2) ? 2 : s;
   endfunction

   // Next state from the rules: count samples, wrap periods, gate by volume.
   task automatic model_step();
      int  n_pre, n_phase, n_scale, n_pwm;
      bit  n_tick, n_ps, n_tone, n_audio;
      if (rst) begin
         n_pre = 0; n_tick = 0; n_phase = 0; n_scale = 41;
         n_ps = 0; n_tone = 0; n_audio = 0; n_pwm = 0;
      end else begin
         n_pwm   = (m_pwm + 1) % 8;
         n_audio = m_tone && (m_pwm < int'(vol));
         n_tone  = en && (m_phase < m_scale / 2);
         n_tick  = en && (m_pre == DIV - 1);
         n_pre   = en ? (m_pre + 1) % DIV : 0;
         n_ps    = 0;
         n_phase = m_phase;
         n_scale = m_scale;
         if (!en) begin
            n_phase = 0;
            n_scale = clampi(int'(scale));
         end else if (m_tick) begin
            if (m_phase + 1 == m_scale) begin
               n_phase = 0;
               n_scale = clampi(int'(scale));
               n_ps    = 1;
            end else begin
               n_phase = m_phase + 1;
            end
         end
      end
      m_pre = n_pre; m_tick = n_tick; m_phase = n_phase; m_scale = n_scale;
      m_ps = n_ps; m_tone = n_tone; m_audio = n_audio; m_pwm = n_pwm;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk_eq("sample_tick",  int'(sample_tick),  int'(m_tick));
      chk_eq("period_start", int'(period_start), int'(m_ps));
      chk_eq("tone",         int'(tone),         int'(m_tone));
      chk_eq("audio",        int'(audio),        int'(m_audio));
      chk_eq("active_scale", int'(active_scale), m_scale);
      if (rst || !en) begin
         last_ps = -1;
      end else if (period_start) begin
         if (last_ps >= 0) chk_eq("period_len", cyc - last_ps, exp_len);
         last_ps = cyc;
         exp_len = int'(active_scale) * DIV;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_phase(input int ph, input int budget);
      int k;
      k = 0;
      while (m_phase != ph && k < budget) begin
         step();
         k++;
      end
      chk_eq("wait_phase_timeout", int'(m_phase == ph), 1);
   endtask

   initial begin
      m_pre = 0; m_tick = 0; m_phase = 0; m_scale = 41;
      m_ps = 0; m_tone = 0; m_audio = 0; m_pwm = 0;

      // Reset values
      rst = 1; en = 0; scale = 6'd12; vol = 3'd7;
      run(3);
      chk_eq("reset_active_scale", int'(active_scale), 41);
      chk_eq("reset_tone", int'(tone), 0);

      // Idle then enable at Scale=12
      rst = 0;
      run(2);
      en = 1;
      run(160);

      // Enable held through reset release: first period at 41
      rst = 1;
      step();
      rst = 0;
      run(420);

      // Mid-period change 41 -> 12 at phase 10
      scale = 6'd41;
      wait_phase(0, 300);
      wait_phase(1, 300);
      run(60);
      wait_phase(10, 400);
      scale = 6'd12;
      run(300);

      // Clamped scales
      scale = 6'd0;
      run(120);
      scale = 6'd1;
      run(60);

      // Volume extremes
      scale = 6'd12;
      vol = 3'd0;
      run(120);
      vol = 3'd4;
      run(120);

      // Disable at phase 5, re-enable at 20, then reset mid-period
      wait_phase(5, 400);
      en = 0;
      step();
      chk_eq("disable_tone", int'(tone), 0);
      run(6);
      scale = 6'd20;
      en = 1;
      run(260);
      wait_phase(7, 400);
      rst = 1;
      step();
      chk_eq("midreset_scale", int'(active_scale), 41);
      chk_eq("midreset_ps", int'(period_start), 0);
      rst = 0;
      run(200);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         if (en ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0))
            en = ~en;
         if ($urandom_range(0, 59) == 0) scale = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 19) == 0) vol = 3'($urandom_range(0, 7));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tone_synth.md
# tone_synth

Downstream consumer of the frequency-select stage's 6-bit `Scale` word. Turns `Scale` (samples per tone period) into a square-wave tone at a fixed ~12.2 kHz sample rate, then applies a 3-bit volume by PWM gating to drive the on-board audio pin. New `Scale` values take effect only on period boundaries, so tone changes are glitch-free.

## Interface
Parameters:
- `SAMPLE_DIV`, default 8192: sysclk cycles per sample tick (100 MHz / 8192 ≈ 12.2 kHz). Legal range ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `sysclk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `enable`  in  1  1 = generate tone; 0 = hold idle
- `Scale`  in  6  samples per tone period from the frequency-select stage
- `Volume`  in  3  PWM duty in eighths (0 = silent, 7 = 7/8)
- `sample_tick`  out  1  one-cycle strobe per sample
- `period_start`  out  1  one-cycle strobe when a new tone period begins
- `tone`  out  1  registered square wave
- `audio`  out  1  registered PWM-gated tone for the speaker pin
- `active_scale`  out  6  `Scale` value currently in use

## Operation
- Prescaler `pre_cnt` (width clog2(SAMPLE_DIV)):
  - Counts 0..SAMPLE_DIV-1 and wraps while `enable`=1.
  - `sample_tick`=1 (registered) in the cycle after `pre_cnt`==SAMPLE_DIV-1.
  - While `enable`=0, `pre_cnt` holds 0 and no ticks occur.
- Clamping: `clamped` = max(`Scale`, 2); values 0 and 1 are treated as 2.
- Phase counter `phase` (6 bits), advanced on each `sample_tick`:
  - If `phase` == `active_scale`-1: `phase`←0, `active_scale`←`clamped`, `period_start` pulses next cycle.
  - Otherwise `phase`←`phase`+1.
- `Scale` changes mid-period are ignored until the wrap; the current period always completes at its old length.
- While `enable`=0: `phase`←0 and `active_scale`←`clamped` every cycle, so re-enable starts a fresh period at the current `Scale`.
- Tone: `tone`←`enable` & (`phase` < `active_scale`>>1).
  - High for floor(S/2) samples, low for ceil(S/2).
  - Example: S=41 gives 20 high / 21 low; S=12 gives 6 / 6.
- PWM: 3-bit `pwm_cnt` free-runs every sysclk regardless of `enable`.
  - `audio`←`tone` & (`pwm_cnt` < `Volume`).
- Simultaneous events: an `enable` fall on the same cycle as a wrapping tick resolves as disable (phase 0, no `period_start`).

## Timing
- Reset values:
  - Counters: `pre_cnt`=0, `phase`=0, `pwm_cnt`=0.
  - Outputs: `active_scale`=41 (300 Hz default); `sample_tick`, `period_start`, `tone`, `audio` = 0.
- Reset mid-operation: all of the above in the next cycle. The in-flight period is abandoned with no `period_start`.
- Enable held high through reset release: the first period uses 41. Afterwards `Scale` is picked up at the first wrap.
- Tone period = `active_scale` × SAMPLE_DIV sysclk cycles, exact with no drift.
- Latencies:
  - `tone` follows `phase` by one cycle.
  - `audio` follows `tone` by one cycle.
  - `enable` fall → `tone`=0 within 1 cycle and `audio`=0 within 2.
- `Volume` is not sampled at boundaries; it takes effect on the next sysclk.

## Structure
- Shared package holds:
  - `SCALE_W`=6, `SCALE_DEFAULT`=6'd41, `SCALE_FLOOR`=6'd2, `VOL_W`=3.
  - The frequency-select stage uses the same `SCALE_W`.
- One sub-module: `sample_prescaler` (parameter SAMPLE_DIV; ports `sysclk`, `reset`, `enable`, `tick`).
- Phase, tone and PWM logic stay in `tone_synth`.

## Test plan
All scenarios use SAMPLE_DIV=4.
- Reset, `enable`=0 for 2 cycles, `Scale`=12, then `enable`=1 → `active_scale`=12; `sample_tick` every 4 cycles; `period_start` every 48 cycles; `tone` 24 cycles high / 24 low.
- `enable`=1 held through reset release with `Scale`=12 → first period 164 cycles at 41; then 48-cycle periods; `active_scale` changes to 12 only after the first `period_start`.
- Mid-period change 41→12 at `phase`=10 → current period still totals 41 ticks; next period is 12 ticks; exactly one `period_start` between them.
- `Scale`=0 and `Scale`=1 → `active_scale`=2; `tone` alternates 1 tick high / 1 tick low (8-cycle period).
- `Volume`=0 → `audio` always 0. `Volume`=4 → `audio` high 4 of every 8 cycles while `tone`=1, and 0 while `tone`=0.
- `enable` dropped at `phase`=5 → next cycle `phase`=0, `tone`=0, no ticks. Change `Scale`=20 and re-enable → first tick after 4 cycles; periods of 80 cycles. Repeat with `reset` pulsed mid-period → reset values next cycle.
